// File: rtl/apb4_cmd_pkg.sv
// Shared types for the APB4 command master: FSM encoding, default protection, counter sizing.
// No logic and no latency; backpressure does not apply.
package apb4_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb4_cmd_state_e;

  localparam logic [2:0] APB4_PROT_DEFAULT = 3'b000;

  // The wait counter must hold 0..TIMEOUT. A disabled timeout still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb4_cmd_master_if.sv
// Request, response and APB4 master signals of apb4_cmd_master, bundled into one interface.
// Plain wires: no latency. Backpressure is carried by the req/rsp valid-ready pairs and by pready.
interface apb4_cmd_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_write_i;
  logic [ADDR_WIDTH-1:0]   req_addr_i;
  logic [DATA_WIDTH-1:0]   req_wdata_i;
  logic [DATA_WIDTH/8-1:0] req_strb_i;

  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;
  logic                    rsp_err_o;
  logic                    rsp_timeout_o;

  logic [ADDR_WIDTH-1:0]   paddr_o;
  logic [2:0]              pprot_o;
  logic                    psel_o;
  logic                    penable_o;
  logic                    pwrite_o;
  logic [DATA_WIDTH-1:0]   pwdata_o;
  logic [DATA_WIDTH/8-1:0] pstrb_o;
  logic                    pready_i;
  logic [DATA_WIDTH-1:0]   prdata_i;
  logic                    pslverr_i;

  // The command master's own view of the bundle.
  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i,
    input  rsp_ready_i, pready_i, prdata_i, pslverr_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );

  // Requester plus APB slave side.
  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i,
    output rsp_ready_i, pready_i, prdata_i, pslverr_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );
endinterface

// File: rtl/apb4_cmd_timer.sv
// Wait-state counter. expired_o is combinational in the cycle that would be the TIMEOUT-th enabled one.
// No backpressure; TIMEOUT=0 never expires.
module apb4_cmd_timer
  import apb4_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i && (TIMEOUT != 0)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt counts the low-pready cycles already completed, so this one would be number TIMEOUT.
  assign expired_o = (TIMEOUT != 0) && en_i && (cnt == LAST);

endmodule

// File: rtl/apb4_cmd_master.sv
// Runs one APB4 transfer per accepted command. Response is valid 2 cycles after acceptance, plus wait states.
// req_ready is high only while idle; the response is held until rsp_ready; a hung slave is aborted after TIMEOUT.
module apb4_cmd_master
  import apb4_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  apb4_cmd_master_if.master  bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } apb4_cmd_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb4_cmd_rsp_t;

  apb4_cmd_state_e state;
  apb4_cmd_req_t   cmd_q;
  apb4_cmd_rsp_t   rsp_q;
  logic            accept;
  logic            wait_cycle;
  logic            expired;

  assign accept     = (state == ST_IDLE) && bus.req_valid_i;
  assign wait_cycle = (state == ST_ACCESS) && !bus.pready_i;

  apb4_cmd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (accept),
    .en_i      (wait_cycle),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cmd_q <= '0;
      rsp_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            cmd_q.write <= bus.req_write_i;
            cmd_q.addr  <= bus.req_addr_i;
            cmd_q.wdata <= bus.req_wdata_i;
            cmd_q.strb  <= bus.req_write_i ? bus.req_strb_i : '0;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A pready in the expiring cycle still completes normally.
          if (bus.pready_i) begin
            rsp_q.rdata   <= cmd_q.write ? '0 : bus.prdata_i;
            rsp_q.err     <= bus.pslverr_i;
            rsp_q.timeout <= 1'b0;
            state         <= ST_RESP;
          end else if (expired) begin
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes come straight from state so psel drops the moment reset asserts.
  assign bus.req_ready_o   = (state == ST_IDLE);
  assign bus.psel_o        = (state == ST_SETUP) || (state == ST_ACCESS);
  assign bus.penable_o     = (state == ST_ACCESS);
  assign bus.rsp_valid_o   = (state == ST_RESP);

  assign bus.paddr_o       = cmd_q.addr;
  assign bus.pwrite_o      = cmd_q.write;
  assign bus.pwdata_o      = cmd_q.wdata;
  assign bus.pstrb_o       = cmd_q.strb;
  assign bus.pprot_o       = APB4_PROT_DEFAULT;

  assign bus.rsp_rdata_o   = rsp_q.rdata;
  assign bus.rsp_err_o     = rsp_q.err;
  assign bus.rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Bench for apb4_cmd_master: directed scenarios plus random commands, checked every cycle against a transaction-level model.
module tb_apb4_cmd_master;

  localparam int T = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  apb4_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb4_cmd_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (T)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Transaction model: accept edge, response edge, release edge and expected response.
  bit          m_active = 1'b0;
  int          m_n = 0, m_lat = 0, m_rel = 0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0, m_to = 1'b0;
  // Last command seen on the APB payload outputs.
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic        l_wr = 1'b0;
  logic [3:0]  l_strb = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    int   k;
    logic e_sel, e_en, e_rv, e_rdy;
    k = cyc - m_n;
    if (m_active && cyc < m_rel) begin
      e_sel = (k < m_lat);
      e_en  = (k >= 1) && (k < m_lat);
      e_rv  = (k >= m_lat);
      e_rdy = 1'b0;
    end else begin
      e_sel = 1'b0;
      e_en  = 1'b0;
      e_rv  = 1'b0;
      e_rdy = 1'b1;
    end
    chk("psel",      64'(bus.psel_o),      64'(e_sel));
    chk("penable",   64'(bus.penable_o),   64'(e_en));
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(e_rv));
    chk("req_ready", 64'(bus.req_ready_o), 64'(e_rdy));
    chk("pprot",     64'(bus.pprot_o),     64'(0));
    chk("paddr",     64'(bus.paddr_o),     64'(l_addr));
    chk("pwrite",    64'(bus.pwrite_o),    64'(l_wr));
    chk("pwdata",    64'(bus.pwdata_o),    64'(l_wdata));
    chk("pstrb",     64'(bus.pstrb_o),     64'(l_strb));
    if (e_rv) begin
      chk("rsp_rdata",   64'(bus.rsp_rdata_o),   64'(m_rdata));
      chk("rsp_err",     64'(bus.rsp_err_o),     64'(m_err));
      chk("rsp_timeout", 64'(bus.rsp_timeout_o), 64'(m_to));
    end
  end

  task automatic junk_req();
    bus.req_write_i = 1'($urandom_range(0, 1));
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_strb_i  = 4'($urandom_range(0, 15));
  endtask

  // w: ACCESS wait states before pready; h: RESP cycles with rsp_ready low.
  // rst_at >= 0 asserts reset at that cycle offset; pin_lat >= 0 adds literal response checks.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int w, input logic perr,
                         input logic [31:0] rd, input int h, input bit keep_valid,
                         input int rst_at, input int pin_lat, input logic [31:0] pin_rdata,
                         input logic pin_err, input logic pin_to);
    int budget;
    int k;
    bit to;
    bus.req_valid_i = 1'b1;
    bus.req_write_i = wr;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_strb_i  = strb;
    budget = 0;
    while (bus.req_ready_o !== 1'b1 && budget < 20) begin
      @(posedge clk_i); #2;
      budget++;
    end
    if (budget >= 20) begin
      chk("req_ready_wait", 64'(bus.req_ready_o), 64'(1));
      bus.req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #2;
    to      = (w >= T);
    m_n     = cyc;
    m_lat   = 2 + ((w < T) ? w : T - 1);
    m_rel   = m_n + m_lat + 1 + h;
    m_rdata = (to || wr) ? 32'h0 : rd;
    m_err   = to ? 1'b1 : perr;
    m_to    = to;
    l_addr  = addr;
    l_wr    = wr;
    l_wdata = wdata;
    l_strb  = wr ? strb : 4'h0;
    m_active = 1'b1;
    if (keep_valid) junk_req();
    else bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = (h == 0);
    while (cyc < m_rel) begin
      k = cyc - m_n;
      if (rst_at >= 0 && k == rst_at) begin
        rst_i = 1'b1;
        #1;
        chk("rst_psel",      64'(bus.psel_o),      64'(0));
        chk("rst_penable",   64'(bus.penable_o),   64'(0));
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'(1));
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("rst_paddr",     64'(bus.paddr_o),     64'(0));
        m_active = 1'b0;
        l_addr = '0; l_wdata = '0; l_wr = 1'b0; l_strb = '0;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.pready_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        return;
      end
      bus.pready_i  = (k == w + 1);
      bus.prdata_i  = bus.pready_i ? rd : $urandom;
      bus.pslverr_i = bus.pready_i ? perr : 1'($urandom_range(0, 1));
      if (k >= m_lat + h) bus.rsp_ready_i = 1'b1;
      if (pin_lat >= 0 && k == pin_lat - 1)
        chk("pin_rsp_early", 64'(bus.rsp_valid_o), 64'(0));
      if (pin_lat >= 0 && k == pin_lat) begin
        chk("pin_rsp_valid",   64'(bus.rsp_valid_o),   64'(1));
        chk("pin_rsp_rdata",   64'(bus.rsp_rdata_o),   64'(pin_rdata));
        chk("pin_rsp_err",     64'(bus.rsp_err_o),     64'(pin_err));
        chk("pin_rsp_timeout", 64'(bus.rsp_timeout_o), 64'(pin_to));
      end
      if (keep_valid) junk_req();
      @(posedge clk_i); #2;
    end
    m_active        = 1'b0;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_strb_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    bus.prdata_i    = '0;
    bus.pslverr_i   = 1'b0;

    @(posedge clk_i); #2;
    chk("reset_req_ready",   64'(bus.req_ready_o),   64'(1));
    chk("reset_psel",        64'(bus.psel_o),        64'(0));
    chk("reset_rsp_valid",   64'(bus.rsp_valid_o),   64'(0));
    chk("reset_rsp_rdata",   64'(bus.rsp_rdata_o),   64'(0));
    chk("reset_rsp_err",     64'(bus.rsp_err_o),     64'(0));
    chk("reset_rsp_timeout", 64'(bus.rsp_timeout_o), 64'(0));
    chk("reset_pwdata",      64'(bus.pwdata_o),      64'(0));
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    @(posedge clk_i); #2;

    // Zero-wait write, 3-wait read, slave error, timeout, and pready on the last allowed cycle.
    run_cmd(1'b1, 32'h10, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0, 0, 1'b0, -1, 2, 32'h0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h04, 32'hCAFE_0000, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 1, 1'b0, -1, 5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h08, 32'h0, 4'h3, 1, 1'b1, 32'h55AA_55AA, 0, 1'b0, -1, 3, 32'h55AA_55AA, 1'b1, 1'b0);
    run_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 10, 1'b0, 32'h1111_1111, 0, 1'b0, -1, 5, 32'h0, 1'b1, 1'b1);
    run_cmd(1'b0, 32'h0C, 32'h0, 4'h0, 3, 1'b0, 32'h2222_2222, 0, 1'b0, -1, 5, 32'h2222_2222, 1'b0, 1'b0);
    run_cmd(1'b1, 32'h0E, 32'h7777_0000, 4'h9, 4, 1'b0, 32'h3333_3333, 2, 1'b0, -1, 5, 32'h0, 1'b1, 1'b1);

    // Response held 5 cycles with a request pending, then the next command follows at once.
    run_cmd(1'b1, 32'h20, 32'hA5A5_A5A5, 4'h5, 0, 1'b0, 32'h0, 5, 1'b1, -1, 2, 32'h0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h24, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_CAFE, 0, 1'b0, -1, 2, 32'h0BAD_CAFE, 1'b0, 1'b0);

    // Reset in ACCESS drops the transfer; a read afterwards must complete normally.
    run_cmd(0, 32'h30, 32'h0, 4'h0, 6, 1'b0, 32'h0, 0, 1'b0, 2, -1, 32'h0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h34, 32'h0, 4'hF, 1, 1'b0, 32'h600D_F00D, 0, 1'b0, -1, 3, 32'h600D_F00D, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, -1, 32'h0, 1'b0, 1'b0);
    end
    bus.req_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
